// File: rtl/alu_pkg.sv
// Shared op-mode, func and FSM encodings for the ALU issue/sequencing controller.
package alu_pkg;

  localparam logic [2:0] OP_LOGIC   = 3'd0;
  localparam logic [2:0] OP_SHIFT   = 3'd1;
  localparam logic [2:0] OP_ADD_SUB = 3'd2;
  localparam logic [2:0] OP_INT_MUL = 3'd3;
  localparam logic [2:0] OP_INT_DIV = 3'd4;

  localparam logic FUNC_QUOT = 1'b0;
  localparam logic FUNC_REM  = 1'b1;

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_MUL_BUSY = 2'd1;
  localparam logic [1:0] ST_DIV_BUSY = 2'd2;
  localparam logic [1:0] ST_DONE     = 2'd3;

endpackage

// File: rtl/alu_seq_if.sv
// Execute-stage issue bus plus mul/div unit handshakes seen by the sequencer.
interface alu_seq_if #(
  parameter int unsigned DATA_W = 32
);
  logic              i_valid;
  logic [2:0]        i_op_mode;
  logic [1:0]        i_func_op;
  logic [DATA_W-1:0] i_a;
  logic [DATA_W-1:0] i_b;
  logic [DATA_W-1:0] i_comb_result;
  logic              i_flush;
  logic              o_ready;
  logic              o_stall;
  logic              o_valid;
  logic [DATA_W-1:0] o_result;
  logic              o_err;
  logic              o_mul_valid;
  logic              o_div_valid;
  logic [DATA_W-1:0] o_mul_a;
  logic [DATA_W-1:0] o_mul_b;
  logic [DATA_W-1:0] o_div_a;
  logic [DATA_W-1:0] o_div_b;
  logic              i_mul_valid;
  logic              i_div_valid;
  logic [DATA_W-1:0] i_mul_result;
  logic [DATA_W-1:0] i_div_quotient;
  logic [DATA_W-1:0] i_div_remainder;

  // Sequencer side
  modport slave (
    input  i_valid, i_op_mode, i_func_op, i_a, i_b, i_comb_result, i_flush,
    input  i_mul_valid, i_div_valid, i_mul_result, i_div_quotient, i_div_remainder,
    output o_ready, o_stall, o_valid, o_result, o_err,
    output o_mul_valid, o_div_valid, o_mul_a, o_mul_b, o_div_a, o_div_b
  );

  // Execute stage / unit side
  modport master (
    output i_valid, i_op_mode, i_func_op, i_a, i_b, i_comb_result, i_flush,
    output i_mul_valid, i_div_valid, i_mul_result, i_div_quotient, i_div_remainder,
    input  o_ready, o_stall, o_valid, o_result, o_err,
    input  o_mul_valid, o_div_valid, o_mul_a, o_mul_b, o_div_a, o_div_b
  );
endinterface

// File: rtl/alu_busy_timer.sv
// Clearable busy-cycle counter with a terminal-count flag at TIMEOUT-1.
module alu_busy_timer #(
  parameter int unsigned TIMEOUT = 64,
  parameter int unsigned CNT_W   = 7
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic inc,
  output logic tc_c
);

  logic [CNT_W-1:0] cnt_q;

  // Count busy cycles; clear wins over increment
  always_ff @(posedge clk or posedge rst) begin
    if (rst)      cnt_q <= '0;
    else if (clr) cnt_q <= '0;
    else if (inc) cnt_q <= cnt_q + CNT_W'(1);
  end

  assign tc_c = (cnt_q == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/alu_seq.sv
// ALU issue/sequencing controller: single-cycle completion, mul/div launch and capture,
// divide-by-zero short-circuit, per-op timeout and flush.
module alu_seq
  import alu_pkg::*;
#(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = 64,
  parameter int unsigned CNT_W   = 7
) (
  input  logic      i_clk,
  input  logic      i_rst,
  alu_seq_if.slave  bus
);

  logic [1:0]        state_q, state_d;
  logic [DATA_W-1:0] mul_a_q, mul_a_d, mul_b_q, mul_b_d;
  logic [DATA_W-1:0] div_a_q, div_a_d, div_b_q, div_b_d;
  logic [DATA_W-1:0] result_q, result_d;
  logic              err_q, err_d;
  logic              rem_q, rem_d;
  logic              mul_launch_q, mul_launch_d;
  logic              div_launch_q, div_launch_d;
  logic              tmr_clr_c, tmr_inc_c, tmr_tc_c;
  logic              valid_c, err_c, stall_c;
  logic [DATA_W-1:0] result_c;
  logic              unused_func_hi;

  assign unused_func_hi = bus.i_func_op[1];

  alu_busy_timer #(
    .TIMEOUT (TIMEOUT),
    .CNT_W   (CNT_W)
  ) u_timer (
    .clk  (i_clk),
    .rst  (i_rst),
    .clr  (tmr_clr_c),
    .inc  (tmr_inc_c),
    .tc_c (tmr_tc_c)
  );

  // State and datapath registers
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q      <= ST_IDLE;
      mul_a_q      <= '0;
      mul_b_q      <= '0;
      div_a_q      <= '0;
      div_b_q      <= '0;
      result_q     <= '0;
      err_q        <= 1'b0;
      rem_q        <= 1'b0;
      mul_launch_q <= 1'b0;
      div_launch_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      mul_a_q      <= mul_a_d;
      mul_b_q      <= mul_b_d;
      div_a_q      <= div_a_d;
      div_b_q      <= div_b_d;
      result_q     <= result_d;
      err_q        <= err_d;
      rem_q        <= rem_d;
      mul_launch_q <= mul_launch_d;
      div_launch_q <= div_launch_d;
    end
  end

  // Next-state, register updates and same-cycle outputs
  always_comb begin
    state_d      = state_q;
    mul_a_d      = mul_a_q;
    mul_b_d      = mul_b_q;
    div_a_d      = div_a_q;
    div_b_d      = div_b_q;
    result_d     = result_q;
    err_d        = err_q;
    rem_d        = rem_q;
    mul_launch_d = 1'b0;
    div_launch_d = 1'b0;
    tmr_clr_c    = 1'b0;
    tmr_inc_c    = 1'b0;
    valid_c      = 1'b0;
    err_c        = 1'b0;
    stall_c      = 1'b0;
    result_c     = result_q;

    case (state_q)
      ST_IDLE: begin
        if (bus.i_valid && !bus.i_flush) begin
          case (bus.i_op_mode)
            OP_LOGIC, OP_SHIFT, OP_ADD_SUB: begin
              valid_c  = 1'b1;
              result_c = bus.i_comb_result;
            end
            OP_INT_MUL: begin
              mul_a_d      = bus.i_a;
              mul_b_d      = bus.i_b;
              mul_launch_d = 1'b1;
              tmr_clr_c    = 1'b1;
              err_d        = 1'b0;
              stall_c      = 1'b1;
              state_d      = ST_MUL_BUSY;
            end
            OP_INT_DIV: begin
              stall_c = 1'b1;
              err_d   = 1'b0;
              rem_d   = bus.i_func_op[0];
              if (bus.i_b != '0) begin
                div_a_d      = bus.i_a;
                div_b_d      = bus.i_b;
                div_launch_d = 1'b1;
                tmr_clr_c    = 1'b1;
                state_d      = ST_DIV_BUSY;
              end else begin
                // Divide by zero: all-ones quotient, dividend as remainder
                result_d = (bus.i_func_op[0] == FUNC_REM) ? bus.i_a : '1;
                state_d  = ST_DONE;
              end
            end
            default: begin
              valid_c  = 1'b1;
              result_c = '0;
              err_c    = 1'b1;
            end
          endcase
        end
      end
      ST_MUL_BUSY, ST_DIV_BUSY: begin
        tmr_inc_c = 1'b1;
        if (bus.i_flush) begin
          state_d = ST_IDLE;
        end else begin
          stall_c = 1'b1;
          if (state_q == ST_MUL_BUSY && bus.i_mul_valid) begin
            result_d = bus.i_mul_result;
            state_d  = ST_DONE;
          end else if (state_q == ST_DIV_BUSY && bus.i_div_valid) begin
            result_d = (rem_q == FUNC_REM) ? bus.i_div_remainder : bus.i_div_quotient;
            state_d  = ST_DONE;
          end else if (tmr_tc_c) begin
            result_d = '0;
            err_d    = 1'b1;
            state_d  = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        valid_c = !bus.i_flush;
        err_c   = err_q && !bus.i_flush;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign bus.o_ready     = (state_q == ST_IDLE);
  assign bus.o_stall     = stall_c;
  assign bus.o_valid     = valid_c;
  assign bus.o_result    = result_c;
  assign bus.o_err       = err_c;
  assign bus.o_mul_valid = mul_launch_q;
  assign bus.o_div_valid = div_launch_q;
  assign bus.o_mul_a     = mul_a_q;
  assign bus.o_mul_b     = mul_b_q;
  assign bus.o_div_a     = div_a_q;
  assign bus.o_div_b     = div_b_q;

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
Issue/sequencing controller in front of the ALU datapath.
- Accepts one operation per handshake from the execute stage.
- Completes single-cycle ops (LOGIC, SHIFT, INT_ADD_SUB) in the issue cycle.
- Sequences the multi-cycle int_mul/int_div units: launch pulse, operand hold, completion capture, stall generation.
- Handles the divide-by-zero short-circuit, a per-op timeout, and pipeline flush.

Parameters:
DATA_W, 32, operand/result width
TIMEOUT, 64, max cycles to wait for a unit o_valid before aborting (>=2)
CNT_W, 7, busy-counter width; must satisfy 2^CNT_W > TIMEOUT

Ports:
i_clk  in  1  clock, rising edge
i_rst  in  1  reset, asynchronous, active-high
i_valid  in  1  op issue request
i_op_mode  in  3  0 LOGIC, 1 SHIFT, 2 INT_ADD_SUB, 3 INT_MUL, 4 INT_DIV, 5-7 illegal
i_func_op  in  2  for DIV, bit0: 0 quotient, 1 remainder
i_a, i_b  in  DATA_W  operands
i_comb_result  in  DATA_W  muxed single-cycle datapath result
i_flush  in  1  abort in-flight op
o_ready  out  1  controller can accept (state IDLE)
o_stall  out  1  hold upstream pipeline
o_valid  out  1  result valid, one-cycle pulse
o_result  out  DATA_W  result
o_err  out  1  one-cycle pulse on timeout or illegal op
o_mul_valid, o_div_valid  out  1  one-cycle launch pulses to units
o_mul_a, o_mul_b, o_div_a, o_div_b  out  DATA_W  registered operands, stable while busy
i_mul_valid, i_div_valid  in  1  unit completion
i_mul_result, i_div_quotient, i_div_remainder  in  DATA_W  unit outputs

Behaviour:
Reset: i_clk and i_rst are the only clock and reset. All registers clear asynchronously.
- state=IDLE, counter=0, operand and result regs=0.
- o_valid, o_err, o_mul_valid, o_div_valid = 0; o_ready = 1.

FSM states: IDLE, MUL_BUSY, DIV_BUSY, DONE.

IDLE, o_ready=1. On accept (i_valid & ~i_flush):
- op 0-2: o_valid=1 and o_result=i_comb_result combinationally, same cycle. Stay in IDLE. Latency 0.
- op 3: latch a/b into mul operand regs, counter=0, go MUL_BUSY. o_stall=1 combinationally in the accept cycle.
- op 4 with i_b!=0: latch into div operand regs, go DIV_BUSY. o_stall=1 in the accept cycle.
- op 4 with i_b==0: no launch. Result reg = all-ones if func bit0=0, else i_a. Go DONE. o_stall=1 in the accept cycle.
- op 5-7: o_valid=1, o_result=0, o_err=1, same cycle. Stay in IDLE.

MUL_BUSY / DIV_BUSY:
- o_stall=1, o_ready=0.
- Launch pulse (o_mul_valid / o_div_valid) is high only in the first busy cycle.
- Counter increments every busy cycle.
- On unit valid: latch result (quotient or remainder per func bit0, captured at accept), go DONE.
- Else if counter==TIMEOUT-1: result reg=0, set err flag, go DONE.
- Unit valid and timeout in the same cycle: valid wins, no err.

DONE: one cycle. o_valid=1, o_result=result reg, o_err=err flag, o_stall=0, o_ready=0. Next state IDLE.

Flush:
- i_flush in BUSY or DONE: next state IDLE. No o_valid; o_valid is suppressed in a DONE cycle with i_flush. o_stall drops the same cycle.
- i_flush in IDLE blocks accept.
- Late unit valids arriving in IDLE are ignored.

Misc:
- i_valid while not IDLE is ignored; upstream honours o_stall.
- Max mul/div latency = 1 (accept) + busy cycles + 1 (DONE).
- Reset mid-op: immediate return to IDLE; no pulses emitted.

Decomposition:
- Shared alu_pkg: op-mode constants (LOGIC=0 ... INT_DIV=4), FUNC_QUOT=0 / FUNC_REM=1, FSM state encoding.
- One natural sub-module, alu_busy_timer: clearable counter with a terminal-count flag at TIMEOUT-1.
- FSM, operand regs and result mux stay in alu_seq.

Test Plan:
- ADD (op 2), i_comb_result=0x0000_0007 -> o_valid and o_result=7 in the same cycle, o_stall=0, state stays IDLE.
- MUL a=6, b=7; unit returns 42 on the 3rd busy cycle -> o_mul_valid pulses once, o_stall=1 for 4 cycles, then o_valid with result 0x2A in the DONE cycle.
- DIV a=0xFFFF_FFF9, b=2, func=REM; unit returns remainder 0xFFFF_FFFF -> o_result=0xFFFF_FFFF; DIV a=5, b=0 -> no o_div_valid, o_result=0xFFFF_FFFF (quot) or 5 (rem), 2-cycle latency.
- MUL with unit never responding, TIMEOUT=64 -> o_valid and o_err pulse together with o_result=0 at DONE; i_mul_valid coinciding with the terminal count -> normal result, o_err=0.
- i_flush 2 cycles into DIV_BUSY -> IDLE next cycle, no o_valid; later i_div_valid ignored; the next ADD completes normally.
- Assert i_rst asynchronously mid MUL_BUSY -> outputs clear without a clock edge; op 6 after reset -> o_err=1, o_result=0.
